// File: rtl/digit_receiver_if.sv
// Link-side signal bundle for digit_receiver: strobed 3-bit digit inputs plus
// the captured-code outputs consumed by the keylock comparator.
interface digit_receiver_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  in0;
  logic                  in1;
  logic                  in2;
  logic                  controlIn;
  logic                  clear;
  logic [2:0]            digit;
  logic                  digit_valid;
  logic [3*DIGITS-1:0]   code;
  logic                  code_ready;
  logic                  error;
  logic                  timeout;
  logic                  busy;

  modport master (
    output in0, in1, in2, controlIn, clear,
    input  digit, digit_valid, code, code_ready, error, timeout, busy
  );

  modport slave (
    input  in0, in1, in2, controlIn, clear,
    output digit, digit_valid, code, code_ready, error, timeout, busy
  );
endinterface

// File: rtl/digit_receiver.sv
// Receive end of the 3-bit digit link: synchronizes the pins, qualifies the
// strobe width, captures one digit per strobe and shifts it into the code buffer.
module digit_receiver #(
  parameter int unsigned MIN_HIGH = 600000,
  parameter int unsigned MAX_HIGH = 1800000,
  parameter int unsigned TIMEOUT  = 36000000,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned CW       = 32
) (
  input  logic          hwclk,
  input  logic          rst_n,
  digit_receiver_if.slave link
);

  localparam int unsigned NW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] HALF_W = CW'(MIN_HIGH / 2);
  localparam logic [CW-1:0] MIN_W  = CW'(MIN_HIGH);
  localparam logic [CW-1:0] MAX_W  = CW'(MAX_HIGH);
  localparam logic [CW-1:0] SAT_W  = CW'(MAX_HIGH + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [NW-1:0] FULL   = NW'(DIGITS);

  typedef enum logic [1:0] {IDLE, HIGH, ACCEPT, WAIT_LOW} state_t;

  state_t              r_state, w_state_n;
  logic                r_cs_s1, r_cs_s2;
  logic [2:0]          r_ds_s1, r_ds_s2;
  logic [CW-1:0]       r_w, w_w_n;
  logic [CW-1:0]       r_idle, w_idle_n;
  logic [2:0]          r_sample, w_sample_n;
  logic [2:0]          r_digit, w_digit_n;
  logic                r_digit_valid, w_digit_valid_n;
  logic [3*DIGITS-1:0] r_code, w_code_n;
  logic [NW-1:0]       r_count, w_count_n;
  logic                r_error, w_error_n;
  logic                r_timeout, w_timeout_n;
  logic                w_cs;
  logic [2:0]          w_ds;

  assign w_cs = r_cs_s2;
  assign w_ds = r_ds_s2;

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_s1 <= 1'b0;
      r_cs_s2 <= 1'b0;
      r_ds_s1 <= '0;
      r_ds_s2 <= '0;
    end else begin
      r_cs_s1 <= link.controlIn;
      r_cs_s2 <= r_cs_s1;
      r_ds_s1 <= {link.in2, link.in1, link.in0};
      r_ds_s2 <= r_ds_s1;
    end
  end

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_w           <= '0;
      r_idle        <= '0;
      r_sample      <= '0;
      r_digit       <= '0;
      r_digit_valid <= 1'b0;
      r_code        <= '0;
      r_count       <= '0;
      r_error       <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_w           <= w_w_n;
      r_idle        <= w_idle_n;
      r_sample      <= w_sample_n;
      r_digit       <= w_digit_n;
      r_digit_valid <= w_digit_valid_n;
      r_code        <= w_code_n;
      r_count       <= w_count_n;
      r_error       <= w_error_n;
      r_timeout     <= w_timeout_n;
    end
  end

  always_comb begin
    w_state_n       = r_state;
    w_w_n           = r_w;
    w_idle_n        = r_idle;
    w_sample_n      = r_sample;
    w_digit_n       = r_digit;
    w_digit_valid_n = 1'b0;
    w_code_n        = r_code;
    w_count_n       = r_count;
    w_error_n       = 1'b0;
    w_timeout_n     = 1'b0;

    case (r_state)
      IDLE: begin
        if (link.clear) begin
          w_code_n  = '0;
          w_count_n = '0;
        end
        // A strobe rise beats a same-cycle timeout; the idle counter restarts.
        if (w_cs) begin
          w_state_n = HIGH;
          w_w_n     = CW'(1);
          w_idle_n  = '0;
        end else if (link.clear || r_count == '0) begin
          w_idle_n = '0;
        end else if (r_idle >= TO_LAST) begin
          w_code_n    = '0;
          w_count_n   = '0;
          w_idle_n    = '0;
          w_timeout_n = 1'b1;
        end else begin
          w_idle_n = r_idle + CW'(1);
        end
      end

      HIGH: begin
        if (w_cs && r_w != SAT_W) begin
          w_w_n = r_w + CW'(1);
        end
        if (link.clear) begin
          w_code_n  = '0;
          w_count_n = '0;
          w_idle_n  = '0;
          w_state_n = WAIT_LOW;
        end else if (w_cs) begin
          if (r_w > MAX_W || (r_w > HALF_W && w_ds != r_sample)) begin
            w_error_n = 1'b1;
            w_code_n  = '0;
            w_count_n = '0;
            w_state_n = WAIT_LOW;
          end else if (r_w == HALF_W) begin
            w_sample_n = w_ds;
          end
        end else if (r_w >= MIN_W && r_w <= MAX_W) begin
          w_state_n = ACCEPT;
        end else begin
          w_error_n = 1'b1;
          w_code_n  = '0;
          w_count_n = '0;
          w_state_n = IDLE;
        end
      end

      ACCEPT: begin
        w_state_n = IDLE;
        if (link.clear) begin
          w_code_n  = '0;
          w_count_n = '0;
          w_idle_n  = '0;
        end else begin
          w_digit_n       = r_sample;
          w_digit_valid_n = 1'b1;
          if (r_count == FULL) begin
            w_code_n      = '0;
            w_code_n[2:0] = r_sample;
            w_count_n     = NW'(1);
          end else begin
            w_code_n  = {r_code[3*DIGITS-4:0], r_sample};
            w_count_n = r_count + NW'(1);
          end
        end
      end

      WAIT_LOW: begin
        if (!w_cs) begin
          w_state_n = IDLE;
        end
      end

      default: w_state_n = IDLE;
    endcase
  end

  assign link.digit       = r_digit;
  assign link.digit_valid = r_digit_valid;
  assign link.code        = r_code;
  assign link.code_ready  = (r_count == FULL);
  assign link.error       = r_error;
  assign link.timeout     = r_timeout;
  assign link.busy        = (r_state != IDLE);

endmodule

// File: tb/tb_digit_receiver.sv
// Randomized scoreboard bench for digit_receiver: a strobe-level reference model
// predicts accept/error/timeout events that a monitor checks as the DUT pulses.
module tb_digit_receiver;

  localparam int MIN_H = 8;
  localparam int MAX_H = 16;
  localparam int TOUT  = 64;
  localparam int ND    = 4;

  logic hwclk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  digit_receiver_if #(.DIGITS(ND)) link();

  digit_receiver #(
    .MIN_HIGH(MIN_H),
    .MAX_HIGH(MAX_H),
    .TIMEOUT (TOUT),
    .DIGITS  (ND),
    .CW      (32)
  ) dut (
    .hwclk(hwclk),
    .rst_n(rst_n),
    .link (link)
  );

  always #5 hwclk = ~hwclk;
  always @(posedge hwclk) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 0 accept, 1 error, 2 timeout
    int dig;
    int code;
    int ready;
    int cyc;    // expected pulse cycle, -1 when not pinned
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model state: code as an integer, digits held.
  int  m_code = 0;
  int  m_cnt  = 0;

  task automatic push(input int kind, input int dig, input int c);
    ev_t e;
    e.kind = kind; e.dig = dig; e.code = m_code; e.ready = (m_cnt == ND) ? 1 : 0; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic model_flush();
    m_code = 0;
    m_cnt  = 0;
  endtask

  task automatic monitor();
    ev_t e;
    int  k;
    forever begin
      @(negedge hwclk);
      if (rst_n && (link.digit_valid || link.error || link.timeout)) begin
        k = link.digit_valid ? 0 : (link.error ? 1 : 2);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: kind=%0d code=%h at cyc %0d, none expected", k, link.code, cyc);
        end else begin
          e = exp_q.pop_front();
          if (k != e.kind || int'(link.code) != e.code || int'(link.code_ready) != e.ready ||
              (e.kind == 0 && int'(link.digit) != e.dig) || (e.cyc >= 0 && cyc != e.cyc) ||
              (int'(link.digit_valid) + int'(link.error) + int'(link.timeout)) != 1) begin
            errors++;
            $display("FAIL event: got kind=%0d digit=%0d code=%h ready=%0d cyc=%0d, want kind=%0d digit=%0d code=%h ready=%0d cyc=%0d",
                     k, link.digit, link.code, link.code_ready, cyc, e.kind, e.dig, e.code, e.ready, e.cyc);
          end
        end
      end
    end
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (link.digit !== 3'd0 || link.digit_valid !== 1'b0 || link.code !== '0 || link.code_ready !== 1'b0 ||
        link.error !== 1'b0 || link.timeout !== 1'b0 || link.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: digit=%0d dv=%b code=%h ready=%b err=%b to=%b busy=%b, want all 0",
               name, link.digit, link.digit_valid, link.code, link.code_ready, link.error, link.timeout, link.busy);
    end
  endtask

  task automatic check_busy(input string name, input logic want);
    checks++;
    if (link.busy !== want) begin
      errors++;
      $display("FAIL %s: busy=%b want %b", name, link.busy, want);
    end
  endtask

  // mode: 0 plain, 1 data glitch at high cycle 10, 2 clear mid-strobe, 3 clear on accept cycle
  task automatic strobe(input int n, input int d, input int mode, input int gap);
    int c_r;
    logic [2:0] dv;
    dv = 3'(d);
    {link.in2, link.in1, link.in0} = dv;
    @(posedge hwclk); #1;
    link.controlIn = 1'b1;
    c_r = cyc;
    if (mode == 1) begin
      model_flush(); push(1, 0, -1);
    end else if (mode == 2) begin
      model_flush();
    end else if (n < MIN_H || n > MAX_H) begin
      model_flush(); push(1, 0, -1);
    end else if (mode == 3) begin
      model_flush();
    end else begin
      if (m_cnt == ND) begin
        m_code = d; m_cnt = 1;
      end else begin
        m_code = (m_code * 8 + d) % (1 << (3 * ND)); m_cnt++;
      end
      push(0, d, c_r + n + 4);
    end
    for (int i = 1; i < n; i++) begin
      @(posedge hwclk); #1;
      link.clear = (mode == 2 && i == 6);
      if (mode == 1 && i == 10) {link.in2, link.in1, link.in0} = dv ^ 3'b100;
      if (i == 5) check_busy("busy_in_high", 1'b1);
    end
    @(posedge hwclk); #1;
    link.controlIn = 1'b0;
    link.clear     = 1'b0;
    if (gap >= 70 && m_cnt > 0) begin
      model_flush(); push(2, 0, -1);
    end
    for (int j = 1; j <= gap; j++) begin
      @(posedge hwclk); #1;
      link.clear = (mode == 3 && j == 3);
    end
    check_busy("busy_after_gap", 1'b0);
  endtask

  int widths[10] = '{3, 5, 7, 8, 9, 12, 14, 16, 18, 22};

  initial begin
    int n, d, mode, gap, r;
    link.in0 = 1'b0; link.in1 = 1'b0; link.in2 = 1'b0;
    link.controlIn = 1'b0; link.clear = 1'b0;

    fork
      monitor();
      begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
      end
    join_none

    repeat (3) @(posedge hwclk);
    #1 check_idle_outputs("reset_state");
    @(negedge hwclk) rst_n = 1'b1;
    repeat (2) @(posedge hwclk);
    #1 check_idle_outputs("after_reset_release");

    strobe(12, 5, 0, 12);
    strobe(5, 0, 0, 12);
    strobe(12, 1, 0, 12);
    strobe(12, 2, 0, 12);
    strobe(12, 3, 0, 12);
    strobe(12, 4, 0, 12);
    strobe(12, 6, 0, 12);
    strobe(20, 2, 0, 12);
    strobe(12, 3, 1, 12);
    strobe(8, 7, 0, 12);
    strobe(16, 7, 0, 12);
    strobe(7, 1, 0, 12);
    strobe(12, 1, 0, 12);
    strobe(12, 2, 0, 70);
    strobe(5, 1, 0, 100);
    strobe(12, 2, 0, 12);
    strobe(12, 4, 3, 12);
    strobe(14, 5, 2, 12);

    for (int t = 0; t < 150; t++) begin
      n = widths[$urandom_range(0, 9)];
      d = int'($urandom_range(0, 7));
      r = int'($urandom_range(0, 9));
      mode = 0;
      if (r == 7 && n >= 12 && n <= MAX_H) mode = 1;
      else if (r == 8 && n >= 12 && n <= MAX_H) mode = 2;
      else if (r == 9) mode = 3;
      gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(90, 110)) : int'($urandom_range(12, 30));
      strobe(n, d, mode, gap);
    end

    // Reset while a strobe is high; the pin stays high across release.
    strobe(12, 5, 0, 20);
    {link.in2, link.in1, link.in0} = 3'd2;
    @(posedge hwclk); #1;
    link.controlIn = 1'b1;
    repeat (6) @(posedge hwclk);
    #2 rst_n = 1'b0;
    model_flush();
    #1 check_idle_outputs("async_reset_mid_strobe");
    @(negedge hwclk) rst_n = 1'b1;
    push(1, 0, -1);
    repeat (4) @(posedge hwclk);
    #1 link.controlIn = 1'b0;
    repeat (20) @(posedge hwclk);
    #1 check_busy("busy_after_reset_strobe", 1'b0);

    for (int w = 0; w < 200 && exp_q.size() != 0; w++) @(posedge hwclk);
    repeat (10) @(posedge hwclk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d expected events never seen", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
